// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the memory port arbiter
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 28;
  localparam int DEF_DATA_W = 128;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
  typedef enum logic {INST, DATA} arb_owner_t;

endpackage

// File: rtl/mem_arb_grant.sv
// rtl/mem_arb_grant.sv - grant select: fixed data priority, round-robin under MEM_ARB_RR_EN
module mem_arb_grant
  import mem_arb_pkg::*;
(
  input  logic       inst_req,
  input  logic       data_req,
`ifdef MEM_ARB_RR_EN
  input  arb_owner_t last_grant,
`endif
  output logic       grant_valid,
  output arb_owner_t grant_owner
);

  // Pick a winner among the pending clients; ties go to data unless round-robin says otherwise
  always_comb begin
    grant_valid = inst_req | data_req;
    grant_owner = data_req ? DATA : INST;
`ifdef MEM_ARB_RR_EN
    if (inst_req && data_req) begin
      grant_owner = (last_grant == DATA) ? INST : DATA;
    end
`endif
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between I-cache and D-cache (MEM_ARB_RR_EN: round-robin)
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              inst_Read,
  input  logic [ADDR_W-1:0] inst_Address,
  output logic [DATA_W-1:0] inst_Readdata,
  output logic              inst_BusyWait,
  input  logic              data_Read,
  input  logic              data_Write,
  input  logic [ADDR_W-1:0] data_Address,
  input  logic [DATA_W-1:0] data_Writedata,
  output logic [DATA_W-1:0] data_Readdata,
  output logic              data_BusyWait,
  output logic              mem_Read,
  output logic              mem_Write,
  output logic [ADDR_W-1:0] mem_Address,
  output logic [DATA_W-1:0] mem_Writedata,
  input  logic [DATA_W-1:0] mem_Readdata,
  input  logic              mem_BusyWait
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  arb_state_t       state;
  arb_state_t       next_state;
  arb_owner_t       owner;
  arb_owner_t       grant_owner;
  logic             grant_valid;
  logic             done;
  logic [CNT_W-1:0] tmo_cnt;

`ifdef MEM_ARB_RR_EN
  arb_owner_t       last_grant;
`endif

  mem_arb_grant u_grant (
    .inst_req    (inst_Read),
    .data_req    (data_Read | data_Write),
`ifdef MEM_ARB_RR_EN
    .last_grant  (last_grant),
`endif
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; ISSUE falls through to RESP after ACK_TIMEOUT quiet cycles
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (grant_valid) next_state = ISSUE;
      ISSUE: begin
        if (mem_BusyWait) begin
          next_state = WAIT;
        end else if (tmo_cnt == CNT_W'(ACK_TIMEOUT)) begin
          next_state = RESP;
        end
      end
      WAIT:  if (!mem_BusyWait) next_state = RESP;
      RESP:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign done = ((state == ISSUE) || (state == WAIT)) && (next_state == RESP);

  // Grant latching, timeout counting and read-data capture on completion
  always_ff @(posedge clock) begin
    if (reset) begin
      owner         <= INST;
      mem_Read      <= 1'b0;
      mem_Write     <= 1'b0;
      mem_Address   <= '0;
      mem_Writedata <= '0;
      inst_Readdata <= '0;
      data_Readdata <= '0;
      tmo_cnt       <= '0;
    end else begin
      if ((state == IDLE) && grant_valid) begin
        owner     <= grant_owner;
        tmo_cnt   <= '0;
        mem_Read  <= (grant_owner == INST) || !data_Write;
        mem_Write <= (grant_owner == DATA) && data_Write;
        if (grant_owner == DATA) begin
          mem_Address   <= data_Address;
          mem_Writedata <= data_Writedata;
        end else begin
          mem_Address   <= inst_Address;
        end
      end
      if (state == ISSUE) begin
        tmo_cnt <= tmo_cnt + CNT_W'(1);
      end
      if (done) begin
        if (mem_Read) begin
          if (owner == INST) inst_Readdata <= mem_Readdata;
          else               data_Readdata <= mem_Readdata;
        end
        mem_Read  <= 1'b0;
        mem_Write <= 1'b0;
      end
    end
  end

`ifdef MEM_ARB_RR_EN
  // Remember who was granted last so ties alternate
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= INST;
    end else if ((state == IDLE) && grant_valid) begin
      last_grant <= grant_owner;
    end
  end
`endif

  assign inst_BusyWait = inst_Read &
                         !(!reset && (state == RESP) && (owner == INST));
  assign data_BusyWait = (data_Read | data_Write) &
                         !(!reset && (state == RESP) && (owner == DATA));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int ACK_TO = 4;

  logic         clock = 1'b0;
  logic         reset;
  logic         inst_Read;
  logic [27:0]  inst_Address;
  logic [127:0] inst_Readdata;
  logic         inst_BusyWait;
  logic         data_Read;
  logic         data_Write;
  logic [27:0]  data_Address;
  logic [127:0] data_Writedata;
  logic [127:0] data_Readdata;
  logic         data_BusyWait;
  logic         mem_Read;
  logic         mem_Write;
  logic [27:0]  mem_Address;
  logic [127:0] mem_Writedata;
  logic [127:0] mem_Readdata;
  logic         mem_BusyWait;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(28), .DATA_W(128), .ACK_TIMEOUT(ACK_TO)) dut (
    .clock          (clock),
    .reset          (reset),
    .inst_Read      (inst_Read),
    .inst_Address   (inst_Address),
    .inst_Readdata  (inst_Readdata),
    .inst_BusyWait  (inst_BusyWait),
    .data_Read      (data_Read),
    .data_Write     (data_Write),
    .data_Address   (data_Address),
    .data_Writedata (data_Writedata),
    .data_Readdata  (data_Readdata),
    .data_BusyWait  (data_BusyWait),
    .mem_Read       (mem_Read),
    .mem_Write      (mem_Write),
    .mem_Address    (mem_Address),
    .mem_Writedata  (mem_Writedata),
    .mem_Readdata   (mem_Readdata),
    .mem_BusyWait   (mem_BusyWait)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called in the IDLE cycle where the request is sampled; returns in the RESP cycle.
  // b = memory busy cycles starting the cycle after grant, 0 = zero-wait memory.
  task automatic xfer(input string tag, input int b, input logic is_inst, input logic exp_wr,
                      input logic [27:0] exp_addr, input logic [127:0] exp_wd);
    int resp_c;
    resp_c = (b == 0) ? ACK_TO + 2 : b + 2;
    for (int c = 1; c <= resp_c; c++) begin
      step();
      mem_BusyWait = (c <= b);
      if (c < resp_c) begin
        chk({tag, "_mem_rd"}, mem_Read, !exp_wr);
        chk({tag, "_mem_wr"}, mem_Write, exp_wr);
        chk({tag, "_mem_addr"}, mem_Address, exp_addr);
        if (exp_wr) chk({tag, "_mem_wd"}, mem_Writedata, exp_wd);
        chk({tag, "_own_bw"}, is_inst ? inst_BusyWait : data_BusyWait, 1'b1);
      end else begin
        chk({tag, "_resp_rd"}, mem_Read, 1'b0);
        chk({tag, "_resp_wr"}, mem_Write, 1'b0);
        chk({tag, "_resp_bw"}, is_inst ? inst_BusyWait : data_BusyWait, 1'b0);
      end
      chk({tag, "_other_bw"}, is_inst ? data_BusyWait : inst_BusyWait,
          is_inst ? (data_Read | data_Write) : inst_Read);
    end
  endtask

  initial begin
    reset = 1'b1;
    inst_Read = 1'b1;
    inst_Address = '0;
    data_Read = 1'b0;
    data_Write = 1'b0;
    data_Address = '0;
    data_Writedata = '0;
    mem_Readdata = '0;
    mem_BusyWait = 1'b0;

    // reset state; busywait follows the request while reset is high
    step();
    step();
    chk("rst_mem_rd", mem_Read, 1'b0);
    chk("rst_mem_wr", mem_Write, 1'b0);
    chk("rst_mem_addr", mem_Address, 28'h0);
    chk("rst_mem_wd", mem_Writedata, 128'h0);
    chk("rst_inst_rdata", inst_Readdata, 128'h0);
    chk("rst_data_rdata", data_Readdata, 128'h0);
    chk("rst_inst_bw", inst_BusyWait, 1'b1);
    chk("rst_data_bw", data_BusyWait, 1'b0);
    inst_Read = 1'b0;
    reset = 1'b0;
    step();
    chk("idle_mem_rd", mem_Read, 1'b0);

    // I-cache refill, memory busy 5 cycles
    inst_Read = 1'b1;
    inst_Address = 28'h0000010;
    mem_Readdata = {16{8'hA5}};
    xfer("t1", 5, 1'b1, 1'b0, 28'h0000010, 128'h0);
    chk("t1_rdata", inst_Readdata, {16{8'hA5}});
    chk("t1_data_rdata", data_Readdata, 128'h0);
    inst_Read = 1'b0;
    step();
    chk("t1_idle_rd", mem_Read, 1'b0);

    // D-cache refill abandoned by reset during WAIT, then re-requested
    data_Read = 1'b1;
    data_Address = 28'h0000060;
    mem_Readdata = {16{8'h5A}};
    step();
    mem_BusyWait = 1'b1;
    chk("t5_c1_rd", mem_Read, 1'b1);
    step();
    chk("t5_c2_rd", mem_Read, 1'b1);
    reset = 1'b1;
    step();
    chk("t5_rst_rd", mem_Read, 1'b0);
    chk("t5_rst_addr", mem_Address, 28'h0);
    chk("t5_rst_bw", data_BusyWait, 1'b1);
    chk("t5_rst_rdata", data_Readdata, 128'h0);
    reset = 1'b0;
    mem_BusyWait = 1'b0;
    xfer("t5b", 2, 1'b0, 1'b0, 28'h0000060, 128'h0);
    chk("t5b_rdata", data_Readdata, {16{8'h5A}});
    data_Read = 1'b0;
    step();

    // zero-wait D-cache refill: RESP at ACK_TIMEOUT+2
    data_Read = 1'b1;
    data_Address = 28'h0000080;
    mem_Readdata = 128'h0123456789ABCDEF_FEDCBA9876543210;
    xfer("t4", 0, 1'b0, 1'b0, 28'h0000080, 128'h0);
    chk("t4_rdata", data_Readdata, 128'h0123456789ABCDEF_FEDCBA9876543210);
    data_Read = 1'b0;
    step();

    // simultaneous I-refill and D-write-back; last grant was data
    inst_Read = 1'b1;
    inst_Address = 28'h0000040;
    data_Write = 1'b1;
    data_Address = 28'h0000050;
    data_Writedata = {4{32'hDEADBEEF}};
    mem_Readdata = {8{16'h3C3C}};
`ifdef MEM_ARB_RR_EN
    xfer("t3_inst", 1, 1'b1, 1'b0, 28'h0000040, 128'h0);
    chk("t3_inst_rdata", inst_Readdata, {8{16'h3C3C}});
    inst_Read = 1'b0;
    step();
    chk("t3_gap_rd", mem_Read, 1'b0);
    chk("t3_gap_wr", mem_Write, 1'b0);
    chk("t3_gap_bw", data_BusyWait, 1'b1);
    xfer("t3_data", 2, 1'b0, 1'b1, 28'h0000050, {4{32'hDEADBEEF}});
    data_Write = 1'b0;
`else
    xfer("t3_data", 2, 1'b0, 1'b1, 28'h0000050, {4{32'hDEADBEEF}});
    data_Write = 1'b0;
    step();
    chk("t3_gap_rd", mem_Read, 1'b0);
    chk("t3_gap_wr", mem_Write, 1'b0);
    chk("t3_gap_bw", inst_BusyWait, 1'b1);
    xfer("t3_inst", 1, 1'b1, 1'b0, 28'h0000040, 128'h0);
    chk("t3_inst_rdata", inst_Readdata, {8{16'h3C3C}});
    inst_Read = 1'b0;
`endif
    step();

    // read and write together: serviced as a write, busywait low for one RESP cycle
    data_Read = 1'b1;
    data_Write = 1'b1;
    data_Address = 28'h0000070;
    data_Writedata = {4{32'h13579BDF}};
    mem_Readdata = {16{8'hEE}};
    xfer("t6", 1, 1'b0, 1'b1, 28'h0000070, {4{32'h13579BDF}});
    step();
    chk("t6_next_bw", data_BusyWait, 1'b1);
    chk("t6_next_rd", mem_Read, 1'b0);
    xfer("t6b", 1, 1'b0, 1'b1, 28'h0000070, {4{32'h13579BDF}});
    chk("t6_rdata_kept", data_Readdata, 128'h0123456789ABCDEF_FEDCBA9876543210);
    data_Read = 1'b0;
    data_Write = 1'b0;
    step();
    chk("end_idle_rd", mem_Read, 1'b0);
    chk("end_idle_wr", mem_Write, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
